// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider controller.
// Holds the controller state encoding, the default counter width and the config legality check.
package clk_div_pkg;

    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_e;

    // Arguments are zero-extended by the caller, so any CNT_W up to 32 bits is supported.
    function automatic logic cfg_legal(input logic [31:0] div, input logic [31:0] high);
        return (div >= 32'd2) && (high >= 32'd1) && (high < div);
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter and active ratio registers for the clock divider.
// Produces the divided clock, the end-of-period tick and the wrap flag used by the controller.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned DEF_DIV  = 10,
    parameter int unsigned DEF_HIGH = 5
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W-1:0] ld_div,
    input  logic [CNT_W-1:0] ld_high,
    output logic             wrap,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_div_q, act_div_d;
    logic [CNT_W-1:0] act_high_q, act_high_d;
    logic             run_q, run_d;

    // run is the controller's next-cycle running flag; run_q mirrors its state register.
    assign wrap    = run_q && (cnt_q == (act_div_q - CNT_W'(1)));
    assign tick    = wrap;
    assign clk_out = run_q && (cnt_q < act_high_q);

    // First running cycle and any stopped cycle hold the counter at zero.
    always_comb begin
        run_d      = run;
        cnt_d      = '0;
        act_div_d  = act_div_q;
        act_high_d = act_high_q;
        if (load) begin
            act_div_d  = ld_div;
            act_high_d = ld_high;
        end
        if (run && run_q && !wrap) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            run_q      <= 1'b0;
            cnt_q      <= '0;
            act_div_q  <= CNT_W'(DEF_DIV);
            act_high_q <= CNT_W'(DEF_HIGH);
        end else begin
            run_q      <= run_d;
            cnt_q      <= cnt_d;
            act_div_q  <= act_div_d;
            act_high_q <= act_high_d;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time programmable clock-enable generator: config handshake, start/stop FSM and
// shadow registers that defer a ratio change to the next period boundary.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned DEF_DIV  = 10,
    parameter int unsigned DEF_HIGH = 5
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             running
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] sh_div_q, sh_div_d;
    logic [CNT_W-1:0] sh_high_q, sh_high_d;
    logic             cfg_err_q, cfg_err_d;

    logic             xfer;
    logic             legal;
    logic             load;
    logic [CNT_W-1:0] ld_div;
    logic [CNT_W-1:0] ld_high;
    logic             run_nxt;
    logic             wrap;

    assign cfg_ready = (state_q != ST_PEND);
    assign running   = (state_q != ST_IDLE);
    assign cfg_err   = cfg_err_q;

    assign xfer    = cfg_valid && cfg_ready;
    assign legal   = cfg_legal(32'(cfg_div), 32'(cfg_high));
    assign run_nxt = (state_d != ST_IDLE);

    // Next state, shadow capture and the load strobe into the core.
    always_comb begin
        state_d   = state_q;
        sh_div_d  = sh_div_q;
        sh_high_d = sh_high_q;
        cfg_err_d = xfer && !legal;
        load      = 1'b0;
        ld_div    = cfg_div;
        ld_high   = cfg_high;

        case (state_q)
            ST_IDLE: begin
                if (xfer && legal) begin
                    load = 1'b1;
                end
                if (en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A config arriving while stopping is applied directly, like a pending one would be.
                if (xfer && legal) begin
                    if (wrap || !en) begin
                        load = 1'b1;
                    end else begin
                        sh_div_d  = cfg_div;
                        sh_high_d = cfg_high;
                        state_d   = ST_PEND;
                    end
                end
                if (!en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (wrap || !en) begin
                    load    = 1'b1;
                    ld_div  = sh_div_q;
                    ld_high = sh_high_q;
                    state_d = en ? ST_RUN : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sh_div_q  <= '0;
            sh_high_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_div_q  <= sh_div_d;
            sh_high_q <= sh_high_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    clk_div_core #(
        .CNT_W    (CNT_W),
        .DEF_DIV  (DEF_DIV),
        .DEF_HIGH (DEF_HIGH)
    ) u_core (
        .clk_in  (clk_in),
        .rst     (rst),
        .run     (run_nxt),
        .load    (load),
        .ld_div  (ld_div),
        .ld_high (ld_high),
        .wrap    (wrap),
        .clk_out (clk_out),
        .tick    (tick)
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: ratio changes, deferred config, illegal config, stop and reset.
module tb_clk_div_ctrl;

    localparam int unsigned CNT_W = 16;

    logic             clk_in = 1'b0;
    logic             rst;
    logic             en;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_high;
    logic             cfg_err;
    logic             clk_out;
    logic             tick;
    logic             running;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    clk_div_ctrl #(
        .CNT_W    (CNT_W),
        .DEF_DIV  (10),
        .DEF_HIGH (5)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .running   (running)
    );

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic outs(input string tag, input logic rdy, input logic err,
                        input logic ck, input logic tk, input logic rn);
        chk($sformatf("%s.cfg_ready", tag), cfg_ready, rdy);
        chk($sformatf("%s.cfg_err", tag), cfg_err, err);
        chk($sformatf("%s.clk_out", tag), clk_out, ck);
        chk($sformatf("%s.tick", tag), tick, tk);
        chk($sformatf("%s.running", tag), running, rn);
    endtask

    task automatic cfg(input logic v, input int d, input int h);
        cfg_valid = v;
        cfg_div   = CNT_W'(d);
        cfg_high  = CNT_W'(h);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        cfg(1'b0, 0, 0);

        // 1: reset values, then default 10/5 ratio
        step();
        step();
        outs("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        en  = 1'b1;
        step();
        for (int k = 0; k < 20; k++) begin
            outs($sformatf("def_c%0d", k % 10), 1'b1, 1'b0, (k % 10) < 5, (k % 10) == 9, 1'b1);
            step();
        end

        // 2: config 4/1 in IDLE together with en=1
        en = 1'b0;
        step();
        outs("stop_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        cfg(1'b1, 4, 1);
        step();
        cfg(1'b0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            outs($sformatf("d4_c%0d", k % 4), 1'b1, 1'b0, (k % 4) < 1, (k % 4) == 3, 1'b1);
            step();
        end

        // 3: back to 10/5, then config 6/3 at cnt=2 is deferred to the wrap
        en = 1'b0;
        step();
        en = 1'b1;
        cfg(1'b1, 10, 5);
        step();
        cfg(1'b0, 0, 0);
        outs("d10_c0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        step();
        outs("d10_c2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cfg(1'b1, 6, 3);
        step();
        cfg(1'b0, 0, 0);
        for (int c = 3; c < 10; c++) begin
            outs($sformatf("pend_c%0d", c), 1'b0, 1'b0, c < 5, c == 9, 1'b1);
            step();
        end
        for (int k = 0; k < 12; k++) begin
            outs($sformatf("d6_c%0d", k % 6), 1'b1, 1'b0, (k % 6) < 3, (k % 6) == 5, 1'b1);
            step();
        end

        // 4: illegal configs pulse cfg_err and leave the 6/3 ratio running
        cfg(1'b1, 5, 5);
        step();
        cfg(1'b0, 0, 0);
        outs("ill55_c1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        outs("ill55_c2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cfg(1'b1, 1, 0);
        step();
        cfg(1'b0, 0, 0);
        outs("ill10_c3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        outs("ill10_c4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        outs("ill_c5", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        // legal config on the wrap cycle applies immediately
        cfg(1'b1, 3, 2);
        step();
        cfg(1'b0, 0, 0);
        outs("wrap3_c0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        outs("wrap3_c1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        outs("wrap3_c2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        outs("wrap3_c0b", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

        // 5: stop while a config is pending; the shadow is applied at stop
        cfg(1'b1, 8, 2);
        step();
        cfg(1'b0, 0, 0);
        outs("pend8_c1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        en = 1'b0;
        step();
        outs("stop_pend", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            outs($sformatf("d8_c%0d", k), 1'b1, 1'b0, k < 2, k == 7, 1'b1);
            step();
        end

        // 6: reset in PEND mid-period restores defaults and drops the shadow
        cfg(1'b1, 4, 2);
        step();
        cfg(1'b0, 0, 0);
        outs("pend4_c1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        outs("pend4_c2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        outs("rst_pend", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        for (int k = 0; k < 10; k++) begin
            outs($sformatf("post_rst_c%0d", k), 1'b1, 1'b0, k < 5, k == 9, 1'b1);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
